// File: rtl/r_resp_mux_s2m.sv
// Read-data (R) channel merge of four slave ports onto one master port.
// A slave is locked from its grant until its RLAST beat completes, so bursts never interleave.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no burst owned; arb_req mirrors s_rvalid, waiting for a grant
// LOCK  | slave grant_q owns the master port until its RLAST handshake
module r_resp_mux_s2m #(
  parameter int ID_W      = 4,
  parameter int DATA_W    = 32,
  parameter int MAX_BEATS = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4*ID_W-1:0]   s_rid,
  input  logic [4*DATA_W-1:0] s_rdata,
  input  logic [7:0]          s_rresp,
  input  logic [3:0]          s_rlast,
  input  logic [3:0]          s_rvalid,
  output logic [3:0]          s_rready,
  output logic [ID_W-1:0]     m_rid,
  output logic [DATA_W-1:0]   m_rdata,
  output logic [1:0]          m_rresp,
  output logic                m_rlast,
  output logic                m_rvalid,
  input  logic                m_rready,
  output logic [3:0]          arb_req,
  input  logic [3:0]          arb_sel,
  output logic                busy,
  output logic                err_overrun
);

  localparam int CNT_W = $clog2(MAX_BEATS) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BEATS - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(MAX_BEATS);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t           state;
  logic [3:0]       grant_q;
  logic [CNT_W-1:0] beat_cnt;

  logic sel_onehot;
  logic sel_hit;
  logic beat_hs;

  assign sel_onehot = (arb_sel != 4'b0000) && ((arb_sel & (arb_sel - 4'd1)) == 4'b0000);
  assign sel_hit    = |(arb_sel & s_rvalid);

  // grant_q is zero outside LOCK, so the mux and ready gating need no state qualifier
  always_comb begin
    m_rid   = '0;
    m_rdata = '0;
    m_rresp = '0;
    for (int i = 0; i < 4; i++) begin
      m_rid   = m_rid   | (s_rid[i*ID_W +: ID_W]       & {ID_W{grant_q[i]}});
      m_rdata = m_rdata | (s_rdata[i*DATA_W +: DATA_W] & {DATA_W{grant_q[i]}});
      m_rresp = m_rresp | (s_rresp[i*2 +: 2]           & {2{grant_q[i]}});
    end
  end

  assign m_rvalid = |(s_rvalid & grant_q);
  assign m_rlast  = |(s_rlast & grant_q);
  assign s_rready = grant_q & {4{m_rready}};
  assign beat_hs  = m_rvalid & m_rready;

  // Holding arb_req low while locked freezes the arbiter's last-winner pointer
  assign arb_req = (state == IDLE) ? s_rvalid : 4'b0000;
  assign busy    = (state == LOCK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant_q     <= 4'b0000;
      beat_cnt    <= '0;
      err_overrun <= 1'b0;
    end else begin
      err_overrun <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_onehot && sel_hit) begin
            grant_q  <= arb_sel;
            beat_cnt <= '0;
            state    <= LOCK;
          end
        end
        LOCK: begin
          if (beat_hs) begin
            if (m_rlast) begin
              grant_q  <= 4'b0000;
              beat_cnt <= '0;
              state    <= IDLE;
            end else begin
              if (beat_cnt == CNT_LAST) begin
                err_overrun <= 1'b1;
              end
              // Saturating one past the limit keeps the overrun pulse single-shot
              if (beat_cnt != CNT_SAT) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
              end
            end
          end
        end
        default: begin
          state   <= IDLE;
          grant_q <= 4'b0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_r_resp_mux_s2m.sv
// Directed bench for r_resp_mux_s2m: behavioural slaves, a round-robin arbiter stand-in,
// and per-scenario tasks with hand-derived expectations.
module tb_r_resp_mux_s2m;
  localparam int ID_W      = 4;
  localparam int DATA_W    = 32;
  localparam int MAX_BEATS = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [4*ID_W-1:0]   s_rid;
  logic [4*DATA_W-1:0] s_rdata;
  logic [7:0]          s_rresp;
  logic [3:0]          s_rlast;
  logic [3:0]          s_rvalid;
  logic [3:0]          s_rready;
  logic [ID_W-1:0]     m_rid;
  logic [DATA_W-1:0]   m_rdata;
  logic [1:0]          m_rresp;
  logic                m_rlast;
  logic                m_rvalid;
  logic                m_rready;
  logic [3:0]          arb_req;
  logic [3:0]          arb_sel;
  logic                busy;
  logic                err_overrun;

  always #5 clk = ~clk;

  r_resp_mux_s2m #(.ID_W(ID_W), .DATA_W(DATA_W), .MAX_BEATS(MAX_BEATS)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .arb_req(arb_req), .arb_sel(arb_sel), .busy(busy), .err_overrun(err_overrun)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  int              rem[4];
  int              idx[4];
  logic [ID_W-1:0] rid_v[4];
  logic [DATA_W-1:0] base_v[4];

  logic [1:0] last_q;
  logic       sel_ovr_en;
  logic [3:0] sel_ovr;
  logic [1:0] p;
  logic       found;

  // Round-robin arbiter stand-in: search starts after the last winner
  always_comb begin
    arb_sel = 4'b0000;
    p       = 2'd0;
    found   = 1'b0;
    if (sel_ovr_en) begin
      arb_sel = sel_ovr;
    end else begin
      for (int k = 1; k <= 4; k++) begin
        p = last_q + 2'(k);
        if (!found && arb_req[p]) begin
          arb_sel[p] = 1'b1;
          found      = 1'b1;
        end
      end
    end
  end

  task automatic drive_slaves();
    for (int i = 0; i < 4; i++) begin
      s_rvalid[i]                 = (rem[i] > 0);
      s_rlast[i]                  = (rem[i] == 1);
      s_rid[i*ID_W +: ID_W]       = rid_v[i];
      s_rdata[i*DATA_W +: DATA_W] = base_v[i] + DATA_W'(idx[i]);
      s_rresp[i*2 +: 2]           = 2'(i);
    end
  endtask

  task automatic load(input int i, input int len, input logic [ID_W-1:0] rid,
                      input logic [DATA_W-1:0] base);
    rem[i]    = len;
    idx[i]    = 0;
    rid_v[i]  = rid;
    base_v[i] = base;
    drive_slaves();
  endtask

  task automatic clear_slaves();
    for (int i = 0; i < 4; i++) begin
      rem[i] = 0; idx[i] = 0; rid_v[i] = '0; base_v[i] = '0;
    end
    drive_slaves();
  endtask

  // Advance one cycle; slaves consume beats that handshook at the edge
  task automatic tick();
    logic [3:0] hs;
    logic [3:0] sel_c;
    hs    = s_rvalid & s_rready;
    sel_c = arb_sel;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (hs[i]) begin
        idx[i]++;
        rem[i]--;
      end
    end
    if (rst_n && !sel_ovr_en) begin
      for (int i = 0; i < 4; i++) if (sel_c[i]) last_q = 2'(i);
    end
    drive_slaves();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    sel_ovr_en = 1'b0;
    sel_ovr    = 4'b0000;
    m_rready   = 1'b1;
    last_q     = 2'd3;
    clear_slaves();
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    sel_ovr_en = 1'b0;
    sel_ovr    = 4'b0000;
    m_rready   = 1'b1;
    last_q     = 2'd3;
    clear_slaves();
    #2 rst_n = 1'b0;
    load(0, 2, 4'h5, 32'h55);
    #1;
    vec_cnt++; if (m_rvalid !== 1'b0) begin err_cnt++; $display("FAIL reset_m_rvalid got %b exp 0", m_rvalid); end
    vec_cnt++; if (s_rready !== 4'b0000) begin err_cnt++; $display("FAIL reset_s_rready got %b exp 0000", s_rready); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy got %b exp 0", busy); end
    vec_cnt++; if (m_rlast !== 1'b0) begin err_cnt++; $display("FAIL reset_m_rlast got %b exp 0", m_rlast); end
    vec_cnt++; if (m_rdata !== 32'h0) begin err_cnt++; $display("FAIL reset_m_rdata got %h exp 0", m_rdata); end
    vec_cnt++; if (m_rid !== 4'h0) begin err_cnt++; $display("FAIL reset_m_rid got %h exp 0", m_rid); end
    vec_cnt++; if (m_rresp !== 2'b00) begin err_cnt++; $display("FAIL reset_m_rresp got %b exp 00", m_rresp); end
    vec_cnt++; if (err_overrun !== 1'b0) begin err_cnt++; $display("FAIL reset_err got %b exp 0", err_overrun); end
    vec_cnt++; if (arb_req !== 4'b0001) begin err_cnt++; $display("FAIL reset_arb_req got %b exp 0001", arb_req); end
    tick();
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_held_busy got %b exp 0", busy); end
    clear_slaves();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_bad_sel();
    logic [3:0] bad[4];
    bad[0] = 4'b0011; bad[1] = 4'b0000; bad[2] = 4'b0100; bad[3] = 4'b1111;
    do_reset();
    load(0, 1, 4'h4, 32'h40);
    load(1, 1, 4'h6, 32'h60);
    sel_ovr_en = 1'b1;
    for (int v = 0; v < 4; v++) begin
      sel_ovr = bad[v];
      #1;
      vec_cnt++; if (arb_req !== 4'b0011) begin err_cnt++; $display("FAIL badsel_arb_req v=%0d got %b exp 0011", v, arb_req); end
      tick();
      vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL badsel_busy v=%0d got %b exp 0", v, busy); end
      vec_cnt++; if (m_rvalid !== 1'b0) begin err_cnt++; $display("FAIL badsel_m_rvalid v=%0d got %b exp 0", v, m_rvalid); end
    end
    sel_ovr_en = 1'b0;
    #1;
    tick();
    vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL badsel_grant0_busy got %b exp 1", busy); end
    vec_cnt++; if (m_rid !== 4'h4) begin err_cnt++; $display("FAIL badsel_grant0_rid got %h exp 4", m_rid); end
    vec_cnt++; if (m_rdata !== 32'h40) begin err_cnt++; $display("FAIL badsel_grant0_data got %h exp 40", m_rdata); end
    tick();
    vec_cnt++; if (arb_req !== 4'b0010) begin err_cnt++; $display("FAIL badsel_idle_arb_req got %b exp 0010", arb_req); end
    tick();
    vec_cnt++; if (m_rid !== 4'h6) begin err_cnt++; $display("FAIL badsel_grant1_rid got %h exp 6", m_rid); end
    vec_cnt++; if (m_rresp !== 2'd1) begin err_cnt++; $display("FAIL badsel_grant1_resp got %b exp 01", m_rresp); end
    tick();
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL badsel_end_busy got %b exp 0", busy); end
  endtask

  task automatic test_single_burst();
    do_reset();
    load(0, 4, 4'd3, 32'hA0);
    #1;
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL single_c1_busy got %b exp 0", busy); end
    vec_cnt++; if (arb_req !== 4'b0001) begin err_cnt++; $display("FAIL single_c1_arb_req got %b exp 0001", arb_req); end
    vec_cnt++; if (m_rvalid !== 1'b0) begin err_cnt++; $display("FAIL single_c1_m_rvalid got %b exp 0", m_rvalid); end
    tick();
    for (int b = 0; b < 4; b++) begin
      vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL single_busy b=%0d got %b exp 1", b, busy); end
      vec_cnt++; if (m_rvalid !== 1'b1) begin err_cnt++; $display("FAIL single_m_rvalid b=%0d got %b exp 1", b, m_rvalid); end
      vec_cnt++; if (m_rdata !== 32'hA0 + 32'(b)) begin err_cnt++; $display("FAIL single_data b=%0d got %h exp %h", b, m_rdata, 32'hA0 + 32'(b)); end
      vec_cnt++; if (m_rid !== 4'd3) begin err_cnt++; $display("FAIL single_rid b=%0d got %h exp 3", b, m_rid); end
      vec_cnt++; if (m_rlast !== (b == 3)) begin err_cnt++; $display("FAIL single_rlast b=%0d got %b exp %b", b, m_rlast, (b == 3)); end
      vec_cnt++; if (s_rready !== 4'b0001) begin err_cnt++; $display("FAIL single_s_rready b=%0d got %b exp 0001", b, s_rready); end
      vec_cnt++; if (arb_req !== 4'b0000) begin err_cnt++; $display("FAIL single_arb_req b=%0d got %b exp 0000", b, arb_req); end
      vec_cnt++; if (err_overrun !== 1'b0) begin err_cnt++; $display("FAIL single_err b=%0d got %b exp 0", b, err_overrun); end
      tick();
    end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL single_c6_busy got %b exp 0", busy); end
    vec_cnt++; if (m_rvalid !== 1'b0) begin err_cnt++; $display("FAIL single_c6_m_rvalid got %b exp 0", m_rvalid); end
    vec_cnt++; if (err_overrun !== 1'b0) begin err_cnt++; $display("FAIL single_c6_err got %b exp 0", err_overrun); end
  endtask

  task automatic test_all_slaves();
    logic [3:0] exp_req;
    do_reset();
    for (int i = 0; i < 4; i++) load(i, 2, 4'(8 + i), 32'h100 * 32'(i + 1));
    #1;
    for (int s = 0; s < 4; s++) begin
      exp_req = 4'b1111 << s;
      vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL all_gap_busy s=%0d got %b exp 0", s, busy); end
      vec_cnt++; if (m_rvalid !== 1'b0) begin err_cnt++; $display("FAIL all_gap_m_rvalid s=%0d got %b exp 0", s, m_rvalid); end
      vec_cnt++; if (arb_req !== exp_req) begin err_cnt++; $display("FAIL all_gap_arb_req s=%0d got %b exp %b", s, arb_req, exp_req); end
      tick();
      for (int b = 0; b < 2; b++) begin
        vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL all_busy s=%0d b=%0d got %b exp 1", s, b, busy); end
        vec_cnt++; if (arb_req !== 4'b0000) begin err_cnt++; $display("FAIL all_arb_req s=%0d b=%0d got %b exp 0000", s, b, arb_req); end
        vec_cnt++; if (m_rid !== 4'(8 + s)) begin err_cnt++; $display("FAIL all_rid s=%0d b=%0d got %h exp %h", s, b, m_rid, 4'(8 + s)); end
        vec_cnt++; if (m_rdata !== 32'h100 * 32'(s + 1) + 32'(b)) begin err_cnt++; $display("FAIL all_data s=%0d b=%0d got %h", s, b, m_rdata); end
        vec_cnt++; if (m_rresp !== 2'(s)) begin err_cnt++; $display("FAIL all_resp s=%0d b=%0d got %b exp %b", s, b, m_rresp, 2'(s)); end
        vec_cnt++; if (m_rlast !== (b == 1)) begin err_cnt++; $display("FAIL all_rlast s=%0d b=%0d got %b exp %b", s, b, m_rlast, (b == 1)); end
        vec_cnt++; if (s_rready !== (4'b0001 << s)) begin err_cnt++; $display("FAIL all_s_rready s=%0d b=%0d got %b exp %b", s, b, s_rready, 4'b0001 << s); end
        tick();
      end
    end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL all_end_busy got %b exp 0", busy); end
    vec_cnt++; if (arb_req !== 4'b0000) begin err_cnt++; $display("FAIL all_end_arb_req got %b exp 0000", arb_req); end
  endtask

  task automatic test_backpressure();
    logic [4:0] pat;
    int         exp_i[5];
    pat = 5'b10101;
    exp_i[0] = 0; exp_i[1] = 1; exp_i[2] = 1; exp_i[3] = 2; exp_i[4] = 2;
    m_rready = 1'b1;
    load(2, 3, 4'hC, 32'hC0);
    #1;
    vec_cnt++; if (arb_req !== 4'b0100) begin err_cnt++; $display("FAIL bp_arb_req got %b exp 0100", arb_req); end
    tick();
    for (int c = 0; c < 5; c++) begin
      m_rready = pat[c];
      #1;
      vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL bp_busy c=%0d got %b exp 1", c, busy); end
      vec_cnt++; if (m_rvalid !== 1'b1) begin err_cnt++; $display("FAIL bp_m_rvalid c=%0d got %b exp 1", c, m_rvalid); end
      vec_cnt++; if (m_rdata !== 32'hC0 + 32'(exp_i[c])) begin err_cnt++; $display("FAIL bp_data c=%0d got %h exp %h", c, m_rdata, 32'hC0 + 32'(exp_i[c])); end
      vec_cnt++; if (m_rlast !== (exp_i[c] == 2)) begin err_cnt++; $display("FAIL bp_rlast c=%0d got %b exp %b", c, m_rlast, (exp_i[c] == 2)); end
      vec_cnt++; if (s_rready !== (pat[c] ? 4'b0100 : 4'b0000)) begin err_cnt++; $display("FAIL bp_s_rready c=%0d got %b", c, s_rready); end
      tick();
    end
    m_rready = 1'b1;
    #1;
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL bp_end_busy got %b exp 0", busy); end
  endtask

  task automatic test_late_request();
    load(1, 3, 4'h1, 32'h1000);
    #1;
    vec_cnt++; if (arb_req !== 4'b0010) begin err_cnt++; $display("FAIL late_arb_req got %b exp 0010", arb_req); end
    tick();
    vec_cnt++; if (m_rdata !== 32'h1000) begin err_cnt++; $display("FAIL late_b0_data got %h exp 1000", m_rdata); end
    tick();
    load(3, 1, 4'hD, 32'hD0);
    #1;
    vec_cnt++; if (s_rready !== 4'b0010) begin err_cnt++; $display("FAIL late_b1_s_rready got %b exp 0010", s_rready); end
    vec_cnt++; if (arb_req !== 4'b0000) begin err_cnt++; $display("FAIL late_b1_arb_req got %b exp 0000", arb_req); end
    vec_cnt++; if (m_rdata !== 32'h1001) begin err_cnt++; $display("FAIL late_b1_data got %h exp 1001", m_rdata); end
    tick();
    vec_cnt++; if (m_rlast !== 1'b1) begin err_cnt++; $display("FAIL late_b2_rlast got %b exp 1", m_rlast); end
    vec_cnt++; if (s_rready[3] !== 1'b0) begin err_cnt++; $display("FAIL late_b2_s_rready3 got %b exp 0", s_rready[3]); end
    tick();
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL late_gap_busy got %b exp 0", busy); end
    vec_cnt++; if (arb_req !== 4'b1000) begin err_cnt++; $display("FAIL late_gap_arb_req got %b exp 1000", arb_req); end
    tick();
    vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL late_s3_busy got %b exp 1", busy); end
    vec_cnt++; if (m_rid !== 4'hD) begin err_cnt++; $display("FAIL late_s3_rid got %h exp d", m_rid); end
    vec_cnt++; if (s_rready !== 4'b1000) begin err_cnt++; $display("FAIL late_s3_s_rready got %b exp 1000", s_rready); end
    vec_cnt++; if (m_rlast !== 1'b1) begin err_cnt++; $display("FAIL late_s3_rlast got %b exp 1", m_rlast); end
    tick();
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL late_end_busy got %b exp 0", busy); end
  endtask

  task automatic test_overrun();
    load(0, 6, 4'h7, 32'h700);
    #1;
    tick();
    for (int c = 0; c < 6; c++) begin
      vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL ovr_busy c=%0d got %b exp 1", c, busy); end
      vec_cnt++; if (err_overrun !== (c == 4)) begin err_cnt++; $display("FAIL ovr_err c=%0d got %b exp %b", c, err_overrun, (c == 4)); end
      vec_cnt++; if (m_rdata !== 32'h700 + 32'(c)) begin err_cnt++; $display("FAIL ovr_data c=%0d got %h exp %h", c, m_rdata, 32'h700 + 32'(c)); end
      vec_cnt++; if (m_rlast !== (c == 5)) begin err_cnt++; $display("FAIL ovr_rlast c=%0d got %b exp %b", c, m_rlast, (c == 5)); end
      tick();
    end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL ovr_end_busy got %b exp 0", busy); end
    vec_cnt++; if (err_overrun !== 1'b0) begin err_cnt++; $display("FAIL ovr_end_err got %b exp 0", err_overrun); end
  endtask

  task automatic test_reset_midburst();
    load(0, 4, 4'h2, 32'h200);
    #1;
    tick();
    tick();
    tick();
    vec_cnt++; if (m_rdata !== 32'h202) begin err_cnt++; $display("FAIL rstmid_pre_data got %h exp 202", m_rdata); end
    vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL rstmid_pre_busy got %b exp 1", busy); end
    rst_n = 1'b0;
    #1;
    vec_cnt++; if (m_rvalid !== 1'b0) begin err_cnt++; $display("FAIL rstmid_m_rvalid got %b exp 0", m_rvalid); end
    vec_cnt++; if (s_rready !== 4'b0000) begin err_cnt++; $display("FAIL rstmid_s_rready got %b exp 0000", s_rready); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rstmid_busy got %b exp 0", busy); end
    vec_cnt++; if (arb_req !== 4'b0001) begin err_cnt++; $display("FAIL rstmid_arb_req got %b exp 0001", arb_req); end
    vec_cnt++; if (m_rdata !== 32'h0) begin err_cnt++; $display("FAIL rstmid_data got %h exp 0", m_rdata); end
    tick();
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rstmid_held_busy got %b exp 0", busy); end
    clear_slaves();
    last_q = 2'd3;
    rst_n  = 1'b1;
    #1;
    load(2, 2, 4'hE, 32'hE0);
    #1;
    vec_cnt++; if (arb_req !== 4'b0100) begin err_cnt++; $display("FAIL rstmid_new_arb_req got %b exp 0100", arb_req); end
    tick();
    vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL rstmid_new_busy got %b exp 1", busy); end
    vec_cnt++; if (m_rdata !== 32'hE0) begin err_cnt++; $display("FAIL rstmid_new_b0 got %h exp e0", m_rdata); end
    vec_cnt++; if (s_rready !== 4'b0100) begin err_cnt++; $display("FAIL rstmid_new_s_rready got %b exp 0100", s_rready); end
    tick();
    vec_cnt++; if (m_rdata !== 32'hE1) begin err_cnt++; $display("FAIL rstmid_new_b1 got %h exp e1", m_rdata); end
    vec_cnt++; if (m_rlast !== 1'b1) begin err_cnt++; $display("FAIL rstmid_new_rlast got %b exp 1", m_rlast); end
    tick();
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rstmid_end_busy got %b exp 0", busy); end
  endtask

  initial begin
    rst_n = 1'b1;
    test_reset();
    test_bad_sel();
    test_single_burst();
    test_all_slaves();
    test_backpressure();
    test_late_request();
    test_overrun();
    test_reset_midburst();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/r_resp_mux_s2m.md
# r_resp_mux_s2m

- Master-side read-data (R) channel multiplexer for the AXI crossbar.
- Merges the R channels of 4 slave ports onto one master port.
- Sits directly upstream of the 4-way s2m round-robin arbiter:
  - presents the arbiter's `req[3:0]` while idle;
  - consumes its one-hot `sel[3:0]`;
  - locks the winning slave until the burst's RLAST beat completes, so beats of different bursts never interleave on the master port.

## Interface
Parameters:
- `ID_W`, 4 — RID width per slave.
- `DATA_W`, 32 — RDATA width.
- `MAX_BEATS`, 256 — burst-length limit for overrun detection.

Ports:
- `clk`  in  1  — single clock; all state updates on rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `s_rid`  in  4*ID_W  — slave RIDs, slave i at [i*ID_W +: ID_W].
- `s_rdata`  in  4*DATA_W  — slave RDATA, same packing.
- `s_rresp`  in  8  — slave RRESP, 2 bits per slave.
- `s_rlast`  in  4  — slave RLAST.
- `s_rvalid`  in  4  — slave RVALID.
- `s_rready`  out  4  — RREADY back to slaves.
- `m_rid`  out  ID_W  — master-port RID.
- `m_rdata`  out  DATA_W  — master-port RDATA.
- `m_rresp`  out  2  — master-port RRESP.
- `m_rlast`  out  1  — master-port RLAST.
- `m_rvalid`  out  1  — master-port RVALID.
- `m_rready`  in  1  — master-port RREADY.
- `arb_req`  out  4  — request vector to the round-robin arbiter.
- `arb_sel`  in  4  — one-hot grant from the arbiter; combinational from `arb_req`.
- `busy`  out  1  — high while a burst is locked.
- `err_overrun`  out  1  — one-cycle pulse on burst-length overrun.

## Operation
States: IDLE and LOCK.

- Registers: `state`, one-hot `grant_q[3:0]`, `beat_cnt` of width clog2(MAX_BEATS)+1, `err_overrun`.
- **IDLE**
  - `arb_req = s_rvalid`.
  - If `arb_sel` is exactly one-hot and `arb_sel & s_rvalid` is nonzero: `grant_q <= arb_sel`, `beat_cnt <= 0`, go to LOCK.
  - If `arb_sel` is 0 or not one-hot: stay in IDLE, no grant.
  - `m_rvalid = 0`, `s_rready = 0`.
- **LOCK**
  - `arb_req = 4'b0000`, so the arbiter's last-winner register freezes for the whole burst.
  - Master-port outputs are a pure AND-OR mux of the fields of slave `grant_q`:
    - `m_rvalid = |(s_rvalid & grant_q)`;
    - `m_rid`, `m_rdata`, `m_rresp`, `m_rlast` come from the granted slave.
  - `s_rready = grant_q & {4{m_rready}}`; non-granted slaves always see `s_rready = 0`.
  - Beat handshake: `m_rvalid & m_rready`.
    - Each beat increments `beat_cnt`.
    - A beat with `m_rlast = 1` returns to IDLE, clears `grant_q` and clears `beat_cnt`.
  - Overrun: a non-last beat handshake when `beat_cnt == MAX_BEATS-1` pulses `err_overrun` high for 1 cycle. The lock is held and the count saturates; no other action.
  - Granted slave drops `s_rvalid` mid-burst (legal between beats): `m_rvalid = 0`, lock held, no timeout.
- `busy = (state == LOCK)`.
- Reset:
  - Forces IDLE, `grant_q = 0`, `beat_cnt = 0`, `err_overrun = 0`.
  - Therefore `m_rvalid = 0`, `s_rready = 0`, `busy = 0` and `m_rlast = 0`; `m_r*` data fields are 0.
  - `arb_req` follows `s_rvalid` because the state is IDLE.
  - Reset asserted mid-burst abandons the burst immediately; no beat completes after assertion.

## Timing
- Arbitration latency: 1 cycle.
  - Requests seen in IDLE cycle t are granted at the t edge.
  - The first beat can be presented in cycle t+1.
- Data path in LOCK is combinational; no register is inserted between slave and master. Throughput is 1 beat/cycle.
- Burst release:
  - RLAST handshake in cycle n puts the block in IDLE in cycle n+1.
  - The next grant is taken in that IDLE cycle, with its first beat in n+2.
  - Minimum gap between consecutive bursts is therefore 1 cycle with `m_rvalid = 0`.
- Single-beat burst (RLAST on first beat): IDLE, then LOCK for 1 cycle, then IDLE.
- Simultaneous requests: order is set entirely by the arbiter. This block only guarantees that exactly one slave is served per lock.
- New requests arriving during LOCK are ignored until IDLE; `s_rready = 0` throttles those slaves.

## Test plan
- Reset, then slave 0 sends a 4-beat burst with `m_rready = 1`, RID = 3, data 0xA0..0xA3:
  - grant in cycle 1, beats in cycles 2-5, `busy` low in cycle 6;
  - `s_rready = 4'b0001` during the beats.
- Slaves 0-3 all assert 2-beat bursts at once, arbiter starting from reset:
  - bursts come out in order 0, 1, 2, 3;
  - beats are never interleaved;
  - there is 1 idle cycle between bursts;
  - `arb_req = 0` whenever `busy = 1`.
- Slave 2 sends a 3-beat burst while `m_rready` toggles 1,0,1,0,1:
  - each beat is held stable while stalled;
  - RLAST is accepted on the 5th cycle of LOCK.
- Slave 1 is locked and slave 3 raises `s_rvalid` mid-burst:
  - `s_rready[3]` stays 0;
  - slave 3 is granted right after slave 1's RLAST.
- `MAX_BEATS = 4` and slave 0 sends 5 beats with no RLAST:
  - `err_overrun` pulses once, on the 4th non-last handshake;
  - the lock is held until a later RLAST.
- `rst_n` is asserted in the middle of a 4-beat burst after beat 2:
  - asynchronously `m_rvalid = 0`, `s_rready = 0`, `busy = 0`;
  - after release, a new burst is arbitrated normally.
